// File: rtl/parking_hour_logger_if.sv
// rtl/parking_hour_logger_if.sv - gate, hour and readback signals of the parking hour logger
interface parking_hour_logger_if #(
    parameter int CAPACITY = 3,
    parameter int CNT_W    = 4
) ();
    localparam int OCC_W = $clog2(CAPACITY + 1);

    logic [2:0]       hour;
    logic             hour_tick;
    logic             arrive;
    logic             depart;
    logic [2:0]       rd_addr;
    logic [OCC_W-1:0] occupancy;
    logic             full;
    logic [CNT_W-1:0] rd_data;
    logic [2:0]       rush_start;
    logic [2:0]       rush_end;
    logic             rush_valid;
    logic             day_done;

    modport master (
        output hour, hour_tick, arrive, depart, rd_addr,
        input  occupancy, full, rd_data, rush_start, rush_end, rush_valid, day_done
    );

    modport slave (
        input  hour, hour_tick, arrive, depart, rd_addr,
        output occupancy, full, rd_data, rush_start, rush_end, rush_valid, day_done
    );
endinterface

// File: rtl/parking_hour_logger.sv
// rtl/parking_hour_logger.sv - lot occupancy tracker, per-hour arrival log and rush-hour detector
module parking_hour_logger #(
    parameter int CAPACITY = 3,
    parameter int CNT_W    = 4
) (
    input logic                 clk,
    input logic                 reset,
    parking_hour_logger_if.slave bus
);
    localparam int OCC_W = $clog2(CAPACITY + 1);
    localparam logic [OCC_W-1:0] CAP     = OCC_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {WAIT_FULL, IN_RUSH, DONE} rush_state_t;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] hr_acc_q, hr_acc_d;
    logic [CNT_W-1:0] acc_plus;
    logic [CNT_W-1:0] log_q [8];
    logic [CNT_W-1:0] log_d [8];
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             day_done_q, day_done_d;
    logic             arr_ok;

    rush_state_t      state_q;
    logic [2:0]       rush_start_q;
    logic [2:0]       rush_end_q;
    logic             rush_valid_q;

    always_comb begin
        // A paired arrive+depart is counted even when full; a lone arrive only if a spot is free.
        arr_ok = bus.arrive && (bus.depart || occ_q != CAP);

        occ_d = occ_q;
        if (bus.arrive && !bus.depart && occ_q != CAP)
            occ_d = occ_q + 1'b1;
        else if (bus.depart && !bus.arrive && occ_q != '0)
            occ_d = occ_q - 1'b1;
        full_d = (occ_d == CAP);

        acc_plus = (arr_ok && hr_acc_q != ACC_MAX) ? hr_acc_q + 1'b1 : hr_acc_q;

        hr_acc_d   = hr_acc_q;
        log_d      = log_q;
        day_done_d = day_done_q;
        if (!day_done_q) begin
            if (bus.hour_tick) begin
                log_d[bus.hour] = acc_plus;
                hr_acc_d        = '0;
                if (bus.hour == 3'd7)
                    day_done_d = 1'b1;
            end else begin
                hr_acc_d = acc_plus;
            end
        end

        rd_data_d = log_q[bus.rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q      <= '0;
            full_q     <= 1'b0;
            hr_acc_q   <= '0;
            rd_data_q  <= '0;
            day_done_q <= 1'b0;
            for (int i = 0; i < 8; i++)
                log_q[i] <= '0;
        end else begin
            occ_q      <= occ_d;
            full_q     <= full_d;
            hr_acc_q   <= hr_acc_d;
            rd_data_q  <= rd_data_d;
            day_done_q <= day_done_d;
            for (int i = 0; i < 8; i++)
                log_q[i] <= log_d[i];
        end
    end

    // Transitions look at next-state occupancy so the hour of the triggering pulse is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_FULL;
            rush_start_q <= '0;
            rush_end_q   <= '0;
            rush_valid_q <= 1'b0;
        end else if (!day_done_q) begin
            case (state_q)
                WAIT_FULL: begin
                    if (occ_d == CAP) begin
                        state_q      <= IN_RUSH;
                        rush_start_q <= bus.hour;
                    end
                end
                IN_RUSH: begin
                    if (occ_d == '0) begin
                        state_q      <= DONE;
                        rush_end_q   <= bus.hour;
                        rush_valid_q <= 1'b1;
                    end
                end
                DONE:    state_q <= DONE;
                default: state_q <= WAIT_FULL;
            endcase
        end
    end

    assign bus.occupancy  = occ_q;
    assign bus.full       = full_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rush_start = rush_start_q;
    assign bus.rush_end   = rush_end_q;
    assign bus.rush_valid = rush_valid_q;
    assign bus.day_done   = day_done_q;
endmodule

// File: tb/tb_parking_hour_logger.sv
// tb/tb_parking_hour_logger.sv - directed self-checking bench for parking_hour_logger
module tb_parking_hour_logger;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    parking_hour_logger_if #(.CAPACITY(3), .CNT_W(4)) bus ();

    parking_hour_logger #(.CAPACITY(3), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arrive_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.arrive = 1'b1;
            step(1);
            bus.arrive = 1'b0;
        end
    endtask

    task automatic depart_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.depart = 1'b1;
            step(1);
            bus.depart = 1'b0;
        end
    endtask

    task automatic hour_close(input logic [2:0] h, input logic with_arr);
        bus.hour      = h;
        bus.hour_tick = 1'b1;
        bus.arrive    = with_arr;
        step(1);
        bus.hour_tick = 1'b0;
        bus.arrive    = 1'b0;
    endtask

    task automatic read_log(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus.rd_addr = a;
        step(1);
        check(tag, 32'(bus.rd_data), exp);
    endtask

    initial begin
        reset         = 1'b1;
        bus.hour      = 3'd0;
        bus.hour_tick = 1'b0;
        bus.arrive    = 1'b0;
        bus.depart    = 1'b0;
        bus.rd_addr   = 3'd0;
        step(2);
        reset = 1'b0;

        check("rst_occ",        32'(bus.occupancy),  0);
        check("rst_full",       32'(bus.full),       0);
        check("rst_rd_data",    32'(bus.rd_data),    0);
        check("rst_rush_start", 32'(bus.rush_start), 0);
        check("rst_rush_end",   32'(bus.rush_end),   0);
        check("rst_rush_valid", 32'(bus.rush_valid), 0);
        check("rst_day_done",   32'(bus.day_done),   0);
        for (int a = 0; a < 8; a++)
            read_log(3'(a), 0, "rst_log");

        // hour 0: two arrivals logged at close
        bus.hour = 3'd0;
        arrive_n(2);
        check("h0_occ", 32'(bus.occupancy), 2);
        hour_close(3'd0, 1'b0);
        read_log(3'd0, 2, "log0");
        depart_n(2);
        check("h0_occ_empty", 32'(bus.occupancy), 0);

        // hour 1: arrival coincident with the tick is logged
        hour_close(3'd1, 1'b1);
        check("h1_occ", 32'(bus.occupancy), 1);
        read_log(3'd1, 1, "log1");

        // hour 2: fill, overflow ignored, arrive+depart while full counted
        bus.hour = 3'd2;
        arrive_n(5);
        check("h2_occ_sat",   32'(bus.occupancy),  3);
        check("h2_full",      32'(bus.full),       1);
        check("rush_start",   32'(bus.rush_start), 2);
        check("rush_valid_0", 32'(bus.rush_valid), 0);
        bus.arrive = 1'b1;
        bus.depart = 1'b1;
        step(1);
        bus.arrive = 1'b0;
        bus.depart = 1'b0;
        check("simul_occ", 32'(bus.occupancy), 3);
        hour_close(3'd2, 1'b0);
        read_log(3'd2, 3, "log2");

        hour_close(3'd3, 1'b0);
        hour_close(3'd4, 1'b0);
        read_log(3'd3, 0, "log3");

        // hour 5: empty out, one extra depart ignored
        bus.hour = 3'd5;
        depart_n(2);
        check("h5_occ1",      32'(bus.occupancy),  1);
        check("h5_valid_pre", 32'(bus.rush_valid), 0);
        depart_n(2);
        check("h5_occ0",     32'(bus.occupancy),  0);
        check("h5_full",     32'(bus.full),       0);
        check("rush_end",    32'(bus.rush_end),   5);
        check("rush_valid",  32'(bus.rush_valid), 1);
        hour_close(3'd5, 1'b0);

        // hour 6: refill must not disturb captured rush window
        bus.hour = 3'd6;
        arrive_n(3);
        hour_close(3'd6, 1'b0);
        check("h6_rush_start", 32'(bus.rush_start), 2);
        check("h6_rush_end",   32'(bus.rush_end),   5);
        read_log(3'd6, 3, "log6");

        // hour 7 close ends the day
        check("pre_day_done", 32'(bus.day_done), 0);
        hour_close(3'd7, 1'b0);
        check("day_done", 32'(bus.day_done), 1);

        bus.hour = 3'd0;
        depart_n(1);
        check("post_occ_dec", 32'(bus.occupancy), 2);
        hour_close(3'd0, 1'b1);
        check("post_occ_inc",  32'(bus.occupancy), 3);
        check("post_day_done", 32'(bus.day_done),  1);
        read_log(3'd0, 2, "post_log0");
        read_log(3'd7, 0, "post_log7");
        read_log(3'd2, 3, "post_log2");

        // second day: reset clears everything
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("d2_day_done",   32'(bus.day_done),   0);
        check("d2_occ",        32'(bus.occupancy),  0);
        check("d2_rush_start", 32'(bus.rush_start), 0);
        check("d2_rush_end",   32'(bus.rush_end),   0);
        check("d2_rush_valid", 32'(bus.rush_valid), 0);
        read_log(3'd2, 0, "d2_log2");

        // accumulator saturates at 15
        bus.hour = 3'd1;
        arrive_n(3);
        check("d2_rush_start1", 32'(bus.rush_start), 1);
        for (int i = 0; i < 14; i++) begin
            bus.arrive = 1'b1;
            bus.depart = 1'b1;
            step(1);
        end
        bus.arrive = 1'b0;
        bus.depart = 1'b0;
        hour_close(3'd1, 1'b1);
        read_log(3'd1, 15, "log1_sat");

        // reset in hour 4
        bus.hour = 3'd4;
        arrive_n(1);
        reset = 1'b1;
        step(1);
        check("mid_rst_occ",        32'(bus.occupancy),  0);
        check("mid_rst_full",       32'(bus.full),       0);
        check("mid_rst_rush_start", 32'(bus.rush_start), 0);
        check("mid_rst_rd_data",    32'(bus.rd_data),    0);
        reset = 1'b0;
        read_log(3'd1, 0, "mid_rst_log1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/parking_hour_logger.md
# parking_hour_logger

Downstream consumer of the hour counter in the parking lot simulator. Tracks lot occupancy from gate arrive/depart pulses and logs arrivals per hour into an 8-entry register array indexed by the hour counter's value. Detects the rush-hour window: the first hour the lot fills, and the first later hour it empties. Results are held for display readback after the 8-hour day ends.

## Interface
- CAPACITY, default 3: number of parking spots; occupancy saturates here.
- CNT_W, default 4: width of each per-hour arrival count.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- hour  in  3  current hour from the hour counter (0–7).
- hour_tick  in  1  one-cycle pulse, asserted on the cycle the hour counter advances; hour still shows the ending hour during this cycle.
- arrive  in  1  one-cycle pulse: a car passed the entry gate.
- depart  in  1  one-cycle pulse: a car passed the exit gate.
- rd_addr  in  3  hour whose arrival count is read back.
- occupancy  out  $clog2(CAPACITY+1)  cars currently in the lot.
- full  out  1  occupancy == CAPACITY.
- rd_data  out  CNT_W  arrival count logged for rd_addr; registered.
- rush_start  out  3  hour at which the lot first became full.
- rush_end  out  3  hour at which the lot first became empty after rush_start.
- rush_valid  out  1  both rush_start and rush_end have been captured.
- day_done  out  1  sticky; the hour-7 tick has occurred.

## Operation
- Occupancy update, each clock:
  - arrive only, and not full: +1. Arrive while full is ignored (not counted anywhere).
  - depart only, and occupancy > 0: −1. Depart while empty is ignored.
  - arrive and depart together: occupancy unchanged, and the arrival is counted, including when full.
- Arrival accumulator hr_acc (CNT_W bits):
  - +1 per accepted arrival; saturates at 2^CNT_W−1.
- Hour close, on hour_tick while day_done=0:
  - log[hour] <= hr_acc plus any arrival accepted in the same cycle (saturating).
  - hr_acc <= 0.
  - If hour==7, day_done <= 1.
- After day_done=1:
  - log and hr_acc are frozen and hour_tick is ignored.
  - Occupancy keeps tracking.
  - day_done stays set until reset.
- Rush FSM, states WAIT_FULL, IN_RUSH, DONE:
  - WAIT_FULL → IN_RUSH on the cycle the next-state occupancy equals CAPACITY; rush_start <= hour.
  - IN_RUSH → DONE on the cycle the next-state occupancy equals 0; rush_end <= hour; rush_valid <= 1.
  - DONE is terminal until reset.
  - The FSM also freezes once day_done=1. If the day ends in IN_RUSH, rush_valid stays 0.
- Readback: rd_data <= log[rd_addr] every cycle, independent of day_done.

## Timing
- Reset values, all outputs: occupancy=0, full=0, rd_data=0, rush_start=0, rush_end=0, rush_valid=0, day_done=0.
- Reset also clears all internal state: log[0..7]=0, hr_acc=0, FSM in WAIT_FULL.
- Reset mid-operation overrides every other input in that cycle.
- occupancy and full reflect a pulse on the edge after it is sampled: 1-cycle latency.
- rush_start and rush_end capture the hour value sampled in the same cycle as the qualifying pulse. rush_valid rises on the edge that updates rush_end.
- Log write: visible on rd_data 2 edges after the hour_tick sample when rd_addr is held constant (1 edge to write, 1 edge to read).
- rd_data latency: 1 cycle from rd_addr.
- Fill and empty in consecutive cycles: both transitions are taken, one per cycle.

## Test plan
- Reset then idle:
  - Hold reset 2 cycles.
  - All outputs 0; rd_data=0 for rd_addr 0..7.
- Occupancy bounds, CAPACITY=3:
  - 5 arrive pulses → occupancy=3, full=1; the extra 2 arrivals are not logged.
  - 4 depart pulses → occupancy=0; no underflow.
- Per-hour logging:
  - 2 arrivals in hour 0, then hour_tick with hour=0 → rd_addr=0 reads 2.
  - 1 arrival coincident with the hour_tick for hour=1 (plus 0 earlier) → log[1]=1.
  - Accumulator restarts at 0 for hour 2.
- Rush detection:
  - Fill to 3 during hour=2 → rush_start=2.
  - Empty during hour=5 → rush_end=5, rush_valid=1.
  - Refill in hour 6 → rush outputs unchanged.
- Day end:
  - hour_tick with hour=7 → day_done=1.
  - Later arrivals and hour_tick leave log unchanged; occupancy still updates.
- Simultaneous and reset mid-day:
  - With full=1, apply arrive+depart together → occupancy stays 3, arrival logged.
  - Assert reset in hour 4 → log, rush outputs, and occupancy cleared the next cycle.
